// File: rtl/bcd_down_counter.sv
// Loadable, cascadable BCD down-counter with borrow-in/borrow-out and optional auto-reload.
// Counts one step per bin strobe while running; bout marks the underflow from all-zero.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | stopped; q holds, bin ignored
// ST_RUN  | counting; each bin decrements q, underflow reloads or finishes
// ST_DONE | underflowed with reload disabled; q = 0 until start or load
module bcd_down_counter #(
    parameter int DIGITS = 2,
    parameter bit RELOAD = 1'b1
) (
    input  logic                  clock,
    input  logic                  sclr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  bin,
    output logic [4*DIGITS-1:0]   q,
    output logic                  bout,
    output logic                  running,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic           running_q, running_d;
    logic           done_q, done_d;
    logic [W-1:0]   load_sat;
    logic [W-1:0]   count_dec;
    logic           borrow;
    logic           is_zero;

    // Out-of-range nibbles clamp to 9 so q never leaves valid BCD.
    always_comb begin
        load_sat = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    always_comb begin
        borrow    = 1'b1;
        count_dec = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
    end

    assign is_zero = (count_q == '0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = load_sat;
            shadow_d = load_sat;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (bin) begin
                        if (!is_zero) begin
                            count_d = count_dec;
                        end else if (RELOAD) begin
                            count_d = shadow_q;
                        end else begin
                            count_d = '0;
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            shadow_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign q       = count_q;
    assign running = running_q;
    assign done    = done_q;
    assign bout    = bin & (state_q == ST_RUN) & is_zero;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter: one instance without reload, one with reload, driven by
// per-cycle vectors whose registered results are queued and checked after the edge.
module tb_bcd_down_counter;

    typedef struct {
        bit         sel;
        bit         sclr;
        bit         load;
        logic [7:0] lv;
        bit         start;
        bit         stop;
        bit         bin;
        logic [7:0] eq;
        bit         ebout;
        bit         erun;
        bit         edone;
        string      nm;
    } vec_t;

    logic       clock = 1'b0;
    logic       sclr_s  [2];
    logic       load_s  [2];
    logic [7:0] lv_s    [2];
    logic       start_s [2];
    logic       stop_s  [2];
    logic       bin_s   [2];
    logic [7:0] q0, q1;
    logic       bout0, bout1, run0, run1, done0, done1;

    int n_vec  = 0;
    int n_miss = 0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 clock = ~clock;

    bcd_down_counter #(.DIGITS(2), .RELOAD(1'b0)) dut0 (
        .clock(clock), .sclr(sclr_s[0]), .load(load_s[0]), .load_val(lv_s[0]),
        .start(start_s[0]), .stop(stop_s[0]), .bin(bin_s[0]),
        .q(q0), .bout(bout0), .running(run0), .done(done0)
    );

    bcd_down_counter #(.DIGITS(2), .RELOAD(1'b1)) dut1 (
        .clock(clock), .sclr(sclr_s[1]), .load(load_s[1]), .load_val(lv_s[1]),
        .start(start_s[1]), .stop(stop_s[1]), .bin(bin_s[1]),
        .q(q1), .bout(bout1), .running(run1), .done(done1)
    );

    function automatic vec_t mk(bit sel, bit sclr, bit load, logic [7:0] lv, bit start,
                                bit stop, bit bin, logic [7:0] eq, bit eb, bit er, bit ed,
                                string nm);
        vec_t v;
        v.sel = sel; v.sclr = sclr; v.load = load; v.lv = lv; v.start = start;
        v.stop = stop; v.bin = bin; v.eq = eq; v.ebout = eb; v.erun = er; v.edone = ed;
        v.nm = nm;
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    task automatic step(input vec_t v);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            sclr_s[d]  = (d == int'(v.sel)) ? v.sclr  : 1'b0;
            load_s[d]  = (d == int'(v.sel)) ? v.load  : 1'b0;
            lv_s[d]    = (d == int'(v.sel)) ? v.lv    : 8'h00;
            start_s[d] = (d == int'(v.sel)) ? v.start : 1'b0;
            stop_s[d]  = (d == int'(v.sel)) ? v.stop  : 1'b0;
            bin_s[d]   = (d == int'(v.sel)) ? v.bin   : 1'b0;
        end
        #1;
        chk({v.nm, " bout"}, {7'd0, (v.sel ? bout1 : bout0)}, {7'd0, v.ebout});
        sb.push_back(v);
    endtask

    task automatic idle(input bit sel, input logic [7:0] eq, input bit er, input string nm);
        step(mk(sel, 0, 0, 8'h00, 0, 0, 0, eq, 0, er, 0, nm));
    endtask

    // Registered outputs for each driven cycle are checked just after the edge that samples it.
    initial begin
        vec_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.nm, " q"},       e.sel ? q1 : q0, e.eq);
                chk({e.nm, " running"}, {7'd0, (e.sel ? run1 : run0)},   {7'd0, e.erun});
                chk({e.nm, " done"},    {7'd0, (e.sel ? done1 : done0)}, {7'd0, e.edone});
            end
        end
    end

    initial begin
        int val;
        int nbout;
        for (int d = 0; d < 2; d++) begin
            sclr_s[d] = 1'b0; load_s[d] = 1'b0; lv_s[d] = 8'h00;
            start_s[d] = 1'b0; stop_s[d] = 1'b0; bin_s[d] = 1'b0;
        end

        tbl.push_back(mk(0, 1, 1, 8'h55, 1, 0, 0, 8'h00, 0, 0, 0, "rst0_a"));
        tbl.push_back(mk(0, 1, 1, 8'h55, 1, 0, 0, 8'h00, 0, 0, 0, "rst0_b"));
        tbl.push_back(mk(1, 1, 1, 8'h55, 1, 0, 0, 8'h00, 0, 0, 0, "rst1_a"));
        tbl.push_back(mk(1, 1, 1, 8'h55, 1, 0, 0, 8'h00, 0, 0, 0, "rst1_b"));
        tbl.push_back(mk(0, 0, 1, 8'hAF, 0, 0, 0, 8'h99, 0, 0, 0, "load_af"));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h99, 0, 1, 0, "start_99"));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 1, 8'h98, 0, 1, 0, "bin_start_in_run"));
        tbl.push_back(mk(0, 0, 1, 8'h50, 0, 0, 1, 8'h50, 0, 0, 0, "load_beats_bin"));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h50, 0, 1, 0, "start_50"));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h50, 0, 0, 0, "stop_beats_start"));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 8'h50, 0, 0, 0, "bin_in_idle"));
        tbl.push_back(mk(0, 0, 1, 8'h07, 0, 0, 0, 8'h07, 0, 0, 0, "load_07"));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h07, 0, 1, 0, "start_07"));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, "mid_run_sclr"));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, "bin_after_sclr"));
        foreach (tbl[i]) step(tbl[i]);

        // Countdown from 12 without reload, strobes five cycles apart.
        step(mk(0, 0, 1, 8'h12, 0, 0, 0, 8'h12, 0, 0, 0, "load_12"));
        step(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h12, 0, 1, 0, "start_12"));
        val = 12;
        for (int p = 1; p <= 13; p++) begin
            for (int g = 0; g < 4; g++) idle(0, to_bcd(val), 1, "gap");
            if (val == 0) begin
                step(mk(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 1, 0, 1, "underflow"));
            end else begin
                val--;
                step(mk(0, 0, 0, 8'h00, 0, 0, 1, to_bcd(val), 0, 1, 0, "count"));
            end
        end
        idle(0, 8'h00, 0, "done_one_cycle");
        step(mk(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, "bin_in_done"));
        step(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, "restart_from_done"));
        step(mk(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 1, 0, 1, "underflow_again"));
        step(mk(0, 0, 1, 8'h34, 0, 0, 0, 8'h34, 0, 0, 0, "load_from_done"));
        step(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h34, 0, 1, 0, "start_34"));
        step(mk(0, 0, 0, 8'h00, 0, 0, 1, 8'h33, 0, 1, 0, "bin_33"));

        // Auto-reload from 03.
        step(mk(1, 0, 1, 8'h03, 0, 0, 0, 8'h03, 0, 0, 0, "load_03"));
        step(mk(1, 0, 0, 8'h00, 1, 0, 0, 8'h03, 0, 1, 0, "start_03"));
        val = 3;
        nbout = 0;
        for (int p = 1; p <= 8; p++) begin
            if (val == 0) begin
                val = 3;
                nbout++;
                step(mk(1, 0, 0, 8'h00, 0, 0, 1, to_bcd(val), 1, 1, 0, "reload"));
            end else begin
                val--;
                step(mk(1, 0, 0, 8'h00, 0, 0, 1, to_bcd(val), 0, 1, 0, "reload_count"));
            end
            idle(1, to_bcd(val), 1, "reload_gap");
        end
        chk("reload_bout_tally", 8'(nbout), 8'd2);

        // Shadow of zero with reload: every strobe passes straight through.
        step(mk(1, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, "load_00"));
        step(mk(1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, "start_00"));
        for (int p = 0; p < 3; p++) begin
            step(mk(1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 1, 1, 0, "div_by_1"));
        end

        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            load_s[d] = 1'b0; start_s[d] = 1'b0; stop_s[d] = 1'b0; bin_s[d] = 1'b0;
        end
        @(posedge clock);
        #2;
        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
